// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared constants, state encoding and index helper for the UART TX arbiter
//
// Purpose : FSM state encoding, byte width and a modulo-wrap index
//           increment used by the round-robin picker.
// Ports   : none (package)
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Next requester index after idx, wrapping at n. Anything at or past
  // n-1 wraps to 0, so an out-of-range index can never be produced.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority encoder for round-robin arbitration
//
// Purpose : Finds the first set bit of i_req searching i_last+1, i_last+2, ...
//           with wrap at NREQ. i_last itself is searched last.
// Ports   : i_req  [NREQ-1:0] request mask
//           i_last [IDW-1:0]  previously granted index
//           o_win  [IDW-1:0]  winning index (valid when o_any)
//           o_any             at least one request present
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last,
  output logic [IDW-1:0]  o_win,
  output logic            o_any
);

  always_comb begin
    int idx;
    o_win = '0;
    o_any = 1'b0;
    idx   = int'(i_last);
    for (int k = 0; k < NREQ; k++) begin
      idx = next_idx(idx, NREQ);
      // Constant-index scan keeps every select in range for any NREQ.
      for (int j = 0; j < NREQ; j++) begin
        if (!o_any && (idx == j) && i_req[j]) begin
          o_any = 1'b1;
          o_win = IDW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NREQ producers
//
// Purpose : Grants one byte per turn to a requester, writes it to the UART
//           core and waits for the core's busy cycle to complete.
//           Optional macro UART_ARB_LOCK_EN keeps a multi-byte message
//           (terminated by req_last) contiguous.
// Ports   : i_clk, i_rst                   clock, async active-high reset
//           i_req_valid/i_req_data/i_req_last  producer side
//           o_req_ready [NREQ-1:0]         accept pulse per requester
//           o_tx_data, o_tx_wr, i_tx_busy  UART core side
//           o_grant_id  [IDW-1:0]          last/current granted requester
//           o_active                       accept until core idle again
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [BYTE_W*NREQ-1:0] i_req_data,
  input  logic [NREQ-1:0]        i_req_last,
  output logic [NREQ-1:0]        o_req_ready,
  output logic [BYTE_W-1:0]      o_tx_data,
  output logic                   o_tx_wr,
  input  logic                   i_tx_busy,
  output logic [IDW-1:0]         o_grant_id,
  output logic                   o_active
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [BYTE_W-1:0] r_data_q;
  logic [BYTE_W-1:0] r_tx_hold;
  logic [IDW-1:0]    r_grant_id;
  logic              r_active;

  logic [NREQ-1:0]   w_pick_mask;
  logic [IDW-1:0]    w_win;
  logic              w_any;
  logic              w_accept;
  logic [BYTE_W-1:0] w_win_data;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_req  (w_pick_mask),
    .i_last (r_grant_id),
    .o_win  (w_win),
    .o_any  (w_any)
  );

`ifdef UART_ARB_LOCK_EN
  logic r_locked;
  logic w_win_last;

  always_comb begin
    w_win_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) w_win_last = i_req_last[i];
    end
  end

  // While locked only the owner of the open message may win; the picker
  // then wraps all the way round back to r_grant_id.
  assign w_pick_mask = r_locked ? (i_req_valid & (NREQ'(1) << r_grant_id)) : i_req_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_locked <= 1'b0;
    end else if (w_accept) begin
      r_locked <= ~w_win_last;
    end
  end
`else
  logic w_unused;
  assign w_unused    = ^i_req_last;
  assign w_pick_mask = i_req_valid;
`endif

  // Reset gates the accept so no ready pulse leaks out while rst is high.
  assign w_accept = (r_state == IDLE) && w_any && !i_tx_busy && !i_rst;

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) w_win_data = i_req_data[i*BYTE_W +: BYTE_W];
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_next_state = LOAD;
      LOAD:                    w_next_state = START;
      START:   if (i_tx_busy)  w_next_state = DONE;
      DONE:    if (!i_tx_busy) w_next_state = IDLE;
      default:                 w_next_state = IDLE;
    endcase
  end

  // Outputs. tx_data shows the fresh byte during LOAD and otherwise the
  // byte of the previous LOAD, so it does not move at accept time.
  always_comb begin
    o_req_ready = '0;
    if (w_accept) o_req_ready = NREQ'(1) << w_win;
    o_tx_wr   = (r_state == LOAD);
    o_tx_data = (r_state == LOAD) ? r_data_q : r_tx_hold;
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_q   <= '0;
      r_tx_hold  <= '0;
      r_grant_id <= IDW'(NREQ - 1);
      r_active   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data_q   <= w_win_data;
        r_grant_id <= w_win;
        r_active   <= 1'b1;
      end
      if (r_state == LOAD) r_tx_hold <= r_data_q;
      if ((r_state == DONE) && !i_tx_busy) r_active <= 1'b0;
    end
  end

  assign o_grant_id = r_grant_id;
  assign o_active   = r_active;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_busy;
  logic [IDW-1:0]    grant_id;
  logic              active;
  logic              ext_busy;

  int busy_cnt;
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  logic [NREQ-1:0] rdy_q[$];
  int              rdy_cyc_q[$];
  logic [7:0]      wr_q[$];
  int              wr_cyc_q[$];

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_tx_data   (tx_data),
    .o_tx_wr     (tx_wr),
    .i_tx_busy   (tx_busy),
    .o_grant_id  (grant_id),
    .o_active    (active)
  );

  always #5 clk = ~clk;

  // UART core model: busy from the cycle after tx_wr, for 10 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst)              busy_cnt <= 0;
    else if (tx_wr)       busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || ext_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req_ready != '0) begin
      rdy_q.push_back(req_ready);
      rdy_cyc_q.push_back(cyc);
    end
    if (tx_wr) begin
      wr_q.push_back(tx_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rdy_q.delete(); rdy_cyc_q.delete(); wr_q.delete(); wr_cyc_q.delete();
  endtask

  task automatic wait_wr(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (wr_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!active && busy_cnt == 0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL idle_wait: active=%0b busy_cnt=%0d, required idle", active, busy_cnt); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
    tests++; if (tx_wr !== 1'b0)        begin fails++; $display("FAIL rst_tx_wr: got %b expected 0", tx_wr); end
    tests++; if (tx_data !== 8'h00)     begin fails++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    tests++; if (grant_id !== 2'd3)     begin fails++; $display("FAIL rst_grant_id: got %0d expected 3", grant_id); end
    tests++; if (active !== 1'b0)       begin fails++; $display("FAIL rst_active: got %b expected 0", active); end
    step(5);
    tests++; if (wr_q.size() != 0) begin fails++; $display("FAIL rst_no_wr: got %0d writes expected 0", wr_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [7:0]      exp_d[5];
    logic [NREQ-1:0] exp_r[5];
    bit ok;
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    clear_logs();
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    wait_wr(5, 100, ok);
    req_valid = 4'b0000;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL rr_timeout: got %0d writes expected 5", wr_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++; if (wr_q[i] !== exp_d[i]) begin fails++; $display("FAIL rr_data[%0d]: got %h expected %h", i, wr_q[i], exp_d[i]); end
        tests++; if (rdy_q[i] !== exp_r[i]) begin fails++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, rdy_q[i], exp_r[i]); end
      end
      tests++; if (rdy_q.size() != 5) begin fails++; $display("FAIL rr_ready_count: got %0d expected 5", rdy_q.size()); end
    end
    wait_idle();
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    req_data[23:16] = 8'h5A;
    req_valid = 4'b0100;
    wait_wr(2, 60, ok);
    req_valid = 4'b0000;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL single_timeout: got %0d writes expected 2", wr_q.size());
    end else begin
      tests++; if (rdy_q[0] !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b expected 0100", rdy_q[0]); end
      tests++; if (wr_q[0] !== 8'h5A) begin fails++; $display("FAIL single_data: got %h expected 5a", wr_q[0]); end
      tests++; if (wr_cyc_q[0] != rdy_cyc_q[0] + 1) begin fails++; $display("FAIL single_latency: got %0d expected %0d", wr_cyc_q[0], rdy_cyc_q[0] + 1); end
      tests++; if (rdy_cyc_q[1] != rdy_cyc_q[0] + 13) begin fails++; $display("FAIL single_reaccept: got %0d expected %0d", rdy_cyc_q[1], rdy_cyc_q[0] + 13); end
      tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL single_grant_id: got %0d expected 2", grant_id); end
    end
    wait_idle();
  endtask

  task automatic test_busy_hold();
    bit ok;
    int c;
    clear_logs();
    ext_busy = 1'b1;
    req_data[7:0] = 8'h33;
    req_valid = 4'b0001;
    step(20);
    tests++; if (rdy_q.size() != 0) begin fails++; $display("FAIL busy_no_ready: got %0d expected 0", rdy_q.size()); end
    tests++; if (wr_q.size() != 0)  begin fails++; $display("FAIL busy_no_wr: got %0d expected 0", wr_q.size()); end
    ext_busy = 1'b0;
    c = cyc;
    wait_wr(1, 20, ok);
    req_valid = 4'b0000;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL busy_timeout: got %0d writes expected 1", wr_q.size());
    end else begin
      tests++; if (rdy_cyc_q[0] != c) begin fails++; $display("FAIL busy_grant_cycle: got %0d expected %0d", rdy_cyc_q[0], c); end
      tests++; if (rdy_q[0] !== 4'b0001) begin fails++; $display("FAIL busy_ready: got %b expected 0001", rdy_q[0]); end
      tests++; if (wr_q[0] !== 8'h33 || wr_cyc_q[0] != c + 1) begin fails++; $display("FAIL busy_wr: got %h@%0d expected 33@%0d", wr_q[0], wr_cyc_q[0], c + 1); end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    req_data  = {8'h13, 8'h12, 8'h11, 8'h77};
    req_data[15:8] = 8'h77;
    req_valid = 4'b0010;
    wait_wr(1, 20, ok);
    req_valid = 4'b0000;
    tests++; if (!ok) begin fails++; $display("FAIL mid_timeout: got %0d writes expected 1", wr_q.size()); end
    step(3);
    tests++; if (active !== 1'b1) begin fails++; $display("FAIL mid_active: got %b expected 1", active); end
    rst = 1'b1;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    @(negedge clk);
    tests++; if (active !== 1'b0)    begin fails++; $display("FAIL mid_rst_active: got %b expected 0", active); end
    tests++; if (tx_wr !== 1'b0)     begin fails++; $display("FAIL mid_rst_tx_wr: got %b expected 0", tx_wr); end
    tests++; if (grant_id !== 2'd3)  begin fails++; $display("FAIL mid_rst_grant_id: got %0d expected 3", grant_id); end
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    step(1);
    clear_logs();
    rst = 1'b0;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
    step(1);
    req_valid = 4'b0000;
    wait_wr(1, 5, ok);
    tests++; if (!ok || wr_q[0] !== 8'h10) begin fails++; $display("FAIL mid_first_data: got %0d writes data %h expected 10", wr_q.size(), ok ? wr_q[0] : 8'h00); end
    wait_idle();
  endtask

  task automatic test_lock();
    logic [7:0] exp_d[5];
    bit done;
    int n1;
    int seen;
`ifdef UART_ARB_LOCK_EN
    exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'h0C, 8'h0C};
`else
    exp_d = '{8'hA1, 8'h0C, 8'hA2, 8'h0C, 8'hA3};
`endif
    clear_logs();
    req_data[7:0]  = 8'h0C;
    req_data[15:8] = 8'hA1;
    req_last  = 4'b0001;
    req_valid = 4'b0011;
    done = 1'b0;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      n1 = 0;
      foreach (rdy_q[k]) if (rdy_q[k] == 4'b0010) n1++;
      if (n1 != seen) begin
        seen = n1;
        if (n1 == 1) req_data[15:8] = 8'hA2;
        if (n1 == 2) begin req_data[15:8] = 8'hA3; req_last[1] = 1'b1; end
        if (n1 == 3) req_valid[1] = 1'b0;
      end
      if (wr_q.size() >= 5) begin done = 1'b1; break; end
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    tests++;
    if (!done) begin
      fails++; $display("FAIL lock_timeout: got %0d writes expected 5", wr_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++; if (wr_q[i] !== exp_d[i]) begin fails++; $display("FAIL lock_order[%0d]: got %h expected %h", i, wr_q[i], exp_d[i]); end
      end
    end
    wait_idle();
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    ext_busy  = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_busy_hold();
    test_reset_mid();
    test_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
